mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory access unit: byte/half/word loads and stores with optional
// wait states, little-endian lanes and misaligned-access rejection.
module mem_access_unit #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemSize,
   input  logic        MemUnsigned,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        MisalignFault
);

   localparam int unsigned DEPTH    = 2 ** ADDR_W;
   localparam logic [3:0]  WC       = 4'(WAIT_CYCLES);
   localparam bit          HAS_WAIT = (WAIT_CYCLES != 0);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic              l_rd;
   logic              l_wr;
   logic              l_uns;
   logic [1:0]        l_size;
   logic [ADDR_W+1:0] l_addr;
   logic [31:0]       l_wdata;

   logic [31:0] mem [DEPTH] = '{default: '0};

   logic              req;
   logic              misalign;
   logic              go;
   logic              commit;
   logic              busy;
   logic              c_rd;
   logic              c_wr;
   logic              c_uns;
   logic [1:0]        c_size;
   logic [ADDR_W+1:0] c_addr;
   logic [31:0]       c_wdata;
   logic [ADDR_W-1:0] idx;
   logic [1:0]        lane;
   logic [31:0]       old;
   logic [31:0]       sh;
   logic [31:0]       ld;
   logic [31:0]       wdat;
   logic [3:0]        be;
   logic              unused_hi;

   assign unused_hi = ^ALUResult[31:ADDR_W+2];

   assign req      = MemRead | MemWrite;
   assign misalign = (MemSize == 2'b01 & ALUResult[0])
                   | (MemSize == 2'b10 & |ALUResult[1:0])
                   | (MemSize == 2'b11);
   assign busy     = (state == BUSY);
   assign go       = ~busy & req & ~misalign;
   assign Stall    = (go & HAS_WAIT) | (busy & cnt != 4'd0);
   assign commit   = (go & ~HAS_WAIT) | (busy & cnt == 4'd0);

   // Operands come straight from the pipeline on a zero-wait commit,
   // otherwise from the copy captured when the access was accepted.
   assign c_rd    = busy ? l_rd    : MemRead;
   assign c_wr    = busy ? l_wr    : MemWrite;
   assign c_uns   = busy ? l_uns   : MemUnsigned;
   assign c_size  = busy ? l_size  : MemSize;
   assign c_addr  = busy ? l_addr  : ALUResult[ADDR_W+1:0];
   assign c_wdata = busy ? l_wdata : WriteData;

   assign idx  = c_addr[ADDR_W+1:2];
   assign lane = c_addr[1:0];
   assign old  = mem[idx];
   assign sh   = old >> {lane, 3'b000};

   always_comb begin
      be   = 4'hF;
      wdat = c_wdata;
      ld   = old;
      unique case (c_size)
         2'b00: begin
            be   = 4'b0001 << lane;
            wdat = {4{c_wdata[7:0]}};
            ld   = c_uns ? {24'd0, sh[7:0]}
                         : {{24{sh[7]}}, sh[7:0]};
         end
         2'b01: begin
            be   = lane[1] ? 4'b1100 : 4'b0011;
            wdat = {2{c_wdata[15:0]}};
            ld   = c_uns ? {16'd0, sh[15:0]}
                         : {{16{sh[15]}}, sh[15:0]};
         end
         default: begin
            be   = 4'hF;
            wdat = c_wdata;
            ld   = old;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst && commit && c_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         ReadData      <= 32'd0;
         MisalignFault <= 1'b0;
         l_rd          <= 1'b0;
         l_wr          <= 1'b0;
         l_uns         <= 1'b0;
         l_size        <= 2'b00;
         l_addr        <= '0;
         l_wdata       <= 32'd0;
      end else begin
         MisalignFault <= ~busy & req & misalign;
         if (commit && c_rd) ReadData <= ld;
         unique case (state)
            IDLE: begin
               if (go && HAS_WAIT) begin
                  l_rd    <= MemRead;
                  l_wr    <= MemWrite;
                  l_uns   <= MemUnsigned;
                  l_size  <= MemSize;
                  l_addr  <= ALUResult[ADDR_W+1:0];
                  l_wdata <= WriteData;
                  cnt     <= WC - 4'd1;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
               else state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: one zero-wait and one three-wait instance,
// byte-addressed reference memory and a load-result scoreboard.
module tb_mem_access_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic        rd  [2];
   logic        wr  [2];
   logic        un  [2];
   logic [1:0]  sz  [2];
   logic [31:0] ad  [2];
   logic [31:0] wd  [2];

   wire [31:0] rdata0, rdata1;
   wire        stall0, stall1, fault0, fault1;

   mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst(rst[0]), .MemRead(rd[0]), .MemWrite(wr[0]),
      .MemSize(sz[0]), .MemUnsigned(un[0]), .ALUResult(ad[0]),
      .WriteData(wd[0]), .ReadData(rdata0), .Stall(stall0),
      .MisalignFault(fault0)
   );

   mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst(rst[1]), .MemRead(rd[1]), .MemWrite(wr[1]),
      .MemSize(sz[1]), .MemUnsigned(un[1]), .ALUResult(ad[1]),
      .WriteData(wd[1]), .ReadData(rdata1), .Stall(stall1),
      .MisalignFault(fault1)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] sb [$];
   logic [31:0] held [2];
   bit   [7:0]  mm [2][1024];

   function automatic logic [31:0] get_rd(input int d);
      return (d == 0) ? rdata0 : rdata1;
   endfunction

   function automatic logic get_st(input int d);
      return (d == 0) ? stall0 : stall1;
   endfunction

   function automatic logic get_ft(input int d);
      return (d == 0) ? fault0 : fault1;
   endfunction

   function automatic logic [31:0] mload(input int d, input logic [1:0] s,
                                         input logic u, input logic [31:0] a);
      bit [9:0] b;
      bit [7:0] v8;
      bit [15:0] v16;
      b = a[9:0];
      v8 = mm[d][b];
      v16 = {mm[d][b+10'd1], v8};
      if (s == 2'b00) return u ? {24'd0, v8} : {{24{v8[7]}}, v8};
      if (s == 2'b01) return u ? {16'd0, v16} : {{16{v16[15]}}, v16};
      return {mm[d][b+10'd3], mm[d][b+10'd2], v16};
   endfunction

   task automatic mstore(input int d, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] v);
      bit [9:0] b;
      int n;
      b = a[9:0];
      n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
      for (int i = 0; i < n; i++) mm[d][b + 10'(i)] = v[8*i +: 8];
   endtask

   // One transaction: drive, model, then follow it cycle by cycle.
   task automatic access(input int d, input logic r, input logic w,
                         input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] v);
      int nw;
      bit mis;
      logic [31:0] e;
      nw  = (d == 0) ? 0 : 3;
      mis = (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00)
         || (s == 2'b11);
      @(negedge clk);
      rd[d] = r; wr[d] = w; sz[d] = s; un[d] = u; ad[d] = a; wd[d] = v;
      if (r && !mis) sb.push_back(mload(d, s, u, a));
      if (w && !mis) mstore(d, s, a, v);
      for (int c = 0; c <= nw; c++) begin
         #1;
         n_checks++;
         if (get_st(d) !== (!mis && c < nw)) begin
            n_fail++;
            $display("FAIL stall d%0d a=%h c%0d: got %b expected %b",
                     d, a, c, get_st(d), (!mis && c < nw));
         end
         @(posedge clk);
         #1;
         if (c == 0) begin
            rd[d] = 1'b0; wr[d] = 1'b0;
            ad[d] = $urandom; wd[d] = $urandom;
            sz[d] = 2'($urandom_range(0, 3)); un[d] = 1'($urandom);
         end
         n_checks++;
         if (get_ft(d) !== (mis && c == 0)) begin
            n_fail++;
            $display("FAIL fault d%0d a=%h c%0d: got %b expected %b",
                     d, a, c, get_ft(d), (mis && c == 0));
         end
         if (c < nw) begin
            n_checks++;
            if (get_rd(d) !== held[d]) begin
               n_fail++;
               $display("FAIL early_rdata d%0d c%0d: got %h expected %h",
                        d, c, get_rd(d), held[d]);
            end
         end
      end
      n_checks++;
      if (r && !mis) begin
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty d%0d: got 0 expected 1 entry", d);
         end else begin
            e = sb.pop_front();
            held[d] = e;
            if (get_rd(d) !== e) begin
               n_fail++;
               $display("FAIL load d%0d a=%h sz=%0d u=%b: got %h expected %h",
                        d, a, s, u, get_rd(d), e);
            end
         end
      end else if (get_rd(d) !== held[d]) begin
         n_fail++;
         $display("FAIL rdata_hold d%0d a=%h: got %h expected %h",
                  d, a, get_rd(d), held[d]);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (get_rd(d) !== 32'd0 || get_st(d) !== 1'b0 || get_ft(d) !== 1'b0) begin
            n_fail++;
            $display("FAIL reset d%0d: got rd=%h st=%b ft=%b expected 0/0/0",
                     d, get_rd(d), get_st(d), get_ft(d));
         end
      end
      @(negedge clk);
      rd[0] = 1'b0; wr[0] = 1'b1; sz[0] = 2'b10; ad[0] = 32'h50;
      wd[0] = 32'h77;
      @(posedge clk);
      #1;
      rst[0] = 1'b0; rst[1] = 1'b0; wr[0] = 1'b0;
      access(0, 1, 0, 2'b10, 0, 32'h50, 0);
   endtask

   task automatic test_word_w0();
      access(0, 0, 1, 2'b10, 0, 32'h10, 32'h8000_00F1);
      access(0, 1, 0, 2'b00, 0, 32'h10, 0);
      access(0, 1, 0, 2'b00, 1, 32'h10, 0);
      access(0, 1, 0, 2'b10, 1, 32'h10, 0);
   endtask

   task automatic test_lanes();
      access(0, 0, 1, 2'b10, 0, 32'h20, 32'h1122_3344);
      access(0, 0, 1, 2'b00, 0, 32'h22, 32'hFFFF_FFAA);
      access(0, 1, 0, 2'b10, 0, 32'h20, 0);
      access(0, 0, 1, 2'b01, 0, 32'h22, 32'h1234_BEEF);
      access(0, 1, 0, 2'b01, 1, 32'h22, 0);
      access(0, 1, 0, 2'b01, 0, 32'h22, 0);
      access(0, 1, 0, 2'b00, 0, 32'h23, 0);
      access(0, 1, 0, 2'b00, 1, 32'h21, 0);
   endtask

   task automatic test_misalign();
      access(0, 1, 0, 2'b01, 0, 32'h21, 0);
      @(posedge clk);
      #1;
      n_checks++;
      if (fault0 !== 1'b0) begin
         n_fail++;
         $display("FAIL fault_pulse_width: got %b expected 0", fault0);
      end
      access(0, 0, 1, 2'b10, 0, 32'h22, 32'hFFFF_FFFF);
      access(0, 0, 1, 2'b11, 0, 32'h20, 32'h0BAD_0BAD);
      access(0, 1, 0, 2'b10, 0, 32'h20, 0);
   endtask

   task automatic test_rmw();
      access(0, 0, 1, 2'b10, 0, 32'h30, 32'h0102_0304);
      access(0, 1, 1, 2'b10, 0, 32'h30, 32'hCAFE_F00D);
      access(0, 1, 0, 2'b10, 0, 32'h30, 0);
   endtask

   task automatic test_wrap();
      access(0, 0, 1, 2'b10, 0, 32'h400, 32'h5);
      access(0, 1, 0, 2'b10, 0, 32'h0, 0);
      access(0, 1, 0, 2'b10, 0, 32'h10, 0);
   endtask

   task automatic test_wait_states();
      access(1, 0, 1, 2'b10, 0, 32'h20, 32'h1122_3344);
      access(1, 0, 1, 2'b00, 0, 32'h22, 32'h0000_00AA);
      access(1, 1, 0, 2'b10, 0, 32'h20, 0);
      access(1, 1, 0, 2'b00, 0, 32'h22, 0);
      access(1, 1, 0, 2'b01, 0, 32'h21, 0);
      access(1, 1, 1, 2'b01, 1, 32'h22, 32'h0000_7E57);
      access(1, 1, 0, 2'b10, 0, 32'h20, 0);
   endtask

   task automatic test_abort();
      @(negedge clk);
      rd[1] = 1'b0; wr[1] = 1'b1; sz[1] = 2'b10; un[1] = 1'b0;
      ad[1] = 32'h40; wd[1] = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      wr[1] = 1'b0; rst[1] = 1'b1;
      n_checks++;
      if (stall1 !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_busy_stall: got %b expected 1", stall1);
      end
      @(posedge clk);
      #1;
      rst[1] = 1'b0;
      held[1] = 32'd0;
      n_checks++;
      if (stall1 !== 1'b0 || rdata1 !== 32'd0) begin
         n_fail++;
         $display("FAIL abort_reset: got st=%b rd=%h expected 0/00000000",
                  stall1, rdata1);
      end
      repeat (4) @(posedge clk);
      access(1, 1, 0, 2'b10, 0, 32'h40, 0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; un[d] = 1'b0;
         sz[d] = 2'b00; ad[d] = 32'd0; wd[d] = 32'd0; held[d] = 32'd0;
      end
      test_reset();
      test_word_w0();
      test_lanes();
      test_misalign();
      test_rmw();
      test_wrap();
      test_wait_states();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
